// File: rtl/threshold_scan_ctrl.sv
// Frame scan controller: walks pixel and threshold ROMs in lockstep and
// streams one thresholded bit per pixel, in raster order.
module threshold_scan_ctrl #(
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_PIXELS   = 16384,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] pix_q,
  input  logic [DATA_WIDTH-1:0] thr_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_bit,
  output logic [ADDR_WIDTH-1:0] out_index
);

  localparam int L  = READ_LATENCY;
  localparam int CW = $clog2(FIFO_DEPTH + L + 2);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(NUM_PIXELS - 1);
  localparam logic [CW-1:0]         DEPTH = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0]         PMAX  = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         infl_q, infl_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         wp_q, rp_q;

  // Stage 0 lines up with rom_address; stage L lines up with valid q data.
  logic [L:0]            vld_q;
  logic [ADDR_WIDTH-1:0] tag_q [L+1];

  logic                  fbit_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fidx_q [FIFO_DEPTH];

  logic issue;
  logic push;
  logic pop;
  logic credit;
  logic res;

  assign push   = vld_q[L];
  assign pop    = (cnt_q != '0) && out_ready;
  assign res    = pix_q > thr_q;
  // A pop this cycle frees its slot in time for a new issue.
  assign credit = (cnt_q + infl_q - CW'(pop)) < DEPTH;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (credit) begin
          issue  = 1'b1;
          addr_d = idx_q;
          idx_d  = idx_q + ADDR_WIDTH'(1);
          if (idx_q == LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (infl_q == '0 &&
            (cnt_q == '0 || (cnt_q == CW'(1) && pop)))
          state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign infl_d = infl_q + CW'(issue) - CW'(push);
  assign cnt_d  = cnt_q + CW'(push) - CW'(pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      infl_q  <= '0;
      cnt_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      infl_q  <= infl_d;
      cnt_q   <= cnt_d;
      vld_q   <= {vld_q[L-1:0], issue};
      if (push) wp_q <= (wp_q == PMAX) ? '0 : wp_q + PW'(1);
      if (pop)  rp_q <= (rp_q == PMAX) ? '0 : rp_q + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    tag_q[0] <= idx_q;
    for (int i = 1; i <= L; i++) tag_q[i] <= tag_q[i-1];
    if (push) begin
      fbit_q[wp_q] <= res;
      fidx_q[wp_q] <= tag_q[L];
    end
  end

  assign busy        = (state_q == RUN) || (state_q == DRAIN);
  assign done        = (state_q == DONE);
  assign rom_address = addr_q;
  assign out_valid   = (cnt_q != '0);
  assign out_bit     = out_valid & fbit_q[rp_q];
  assign out_index   = out_valid ? fidx_q[rp_q] : '0;

endmodule

// File: tb/tb_threshold_scan_ctrl.sv
// Bench for threshold_scan_ctrl: full-frame, stall, random backpressure,
// abort, start-while-busy, single-pixel and compare boundary scenarios.
module tb_threshold_scan_ctrl;

  localparam int AW = 14;
  localparam int DW = 8;
  localparam int N  = 16384;
  localparam int L  = 2;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          start = 1'b0;
  logic          busy, done;
  logic [AW-1:0] rom_address;
  logic [DW-1:0] pix_q, thr_q;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_bit;
  logic [AW-1:0] out_index;

  logic          start1 = 1'b0;
  logic          busy1, done1;
  logic [AW-1:0] rom_address1;
  logic [DW-1:0] c40 = 8'h40;
  logic          out_valid1;
  logic          out_ready1 = 1'b1;
  logic          out_bit1;
  logic [AW-1:0] out_index1;

  int n_chk = 0;
  int n_pass = 0;
  bit mode = 1'b0;
  logic [AW:0] exp_q[$];

  always #5 clk = ~clk;

  threshold_scan_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PIXELS(N),
    .READ_LATENCY(L), .FIFO_DEPTH(FD)
  ) u_main (
    .clock(clk), .reset(rst), .start(start),
    .busy(busy), .done(done), .rom_address(rom_address),
    .pix_q(pix_q), .thr_q(thr_q),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit), .out_index(out_index)
  );

  threshold_scan_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PIXELS(1),
    .READ_LATENCY(L), .FIFO_DEPTH(FD)
  ) u_one (
    .clock(clk), .reset(rst), .start(start1),
    .busy(busy1), .done(done1), .rom_address(rom_address1),
    .pix_q(c40), .thr_q(c40),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_bit(out_bit1), .out_index(out_index1)
  );

  function automatic logic [7:0] pixf(input logic [AW-1:0] a, input bit m);
    if (m && a == 0) return 8'hFF;
    if (m && a == 1) return 8'h00;
    if (m && a == 2) return 8'h7F;
    return a[7:0];
  endfunction

  function automatic logic [7:0] thrf(input logic [AW-1:0] a, input bit m);
    if (m && a == 0) return 8'h00;
    if (m && a == 1) return 8'hFF;
    if (m && a == 2) return 8'h7F;
    return 8'h80;
  endfunction

  function automatic logic exp_bit(input int i, input bit m);
    if (m && i == 0) return 1'b1;
    if (m && (i == 1 || i == 2)) return 1'b0;
    return (i % 256) >= 129;
  endfunction

  // Two-cycle synchronous ROM pair
  logic [7:0] p1, t1;
  always @(posedge clk) begin
    p1    <= pixf(rom_address, mode);
    t1    <= thrf(rom_address, mode);
    pix_q <= p1;
    thr_q <= t1;
  end

  task automatic run_frame(input bit m, input int stall_at,
                           input bit rnd, input bit poke,
                           output int pops, output int dones,
                           output int first_v, output int last_pop,
                           output int done_at);
    int k;
    int left;
    bit stalled;
    bit eb;
    logic [AW-1:0] h_idx;
    logic h_bit;
    logic [AW:0] e;
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back({AW'(i), exp_bit(i, m)});
    pops = 0; dones = 0; first_v = -1; last_pop = -1; done_at = -1;
    k = 0; left = 0; stalled = 0;
    @(negedge clk);
    mode = m;
    start = 1'b1;
    out_ready = 1'b1;
    while (k < 4 * N + 1000 && !(done_at >= 0 && k >= done_at + 4)) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      start = poke && (k == 300);
      if (out_valid && first_v < 0) first_v = k;
      eb = (dones == 0) && (done !== 1'b1);
      n_chk++;
      if (busy !== eb)
        $display("FAIL busy k=%0d: got %b want %b", k, busy, eb);
      else n_pass++;
      if (done === 1'b1) begin
        dones++;
        if (done_at < 0) done_at = k;
      end
      if (left > 0) begin
        n_chk++;
        if (out_valid !== 1'b1 || out_index !== h_idx || out_bit !== h_bit)
          $display("FAIL stall_hold: got v=%b idx=%0d bit=%b want 1 %0d %b",
                   out_valid, out_index, out_bit, h_idx, h_bit);
        else n_pass++;
        left--;
        if (left == 0) begin
          n_chk++;
          if (rom_address !== h_idx + AW'(FD - 1))
            $display("FAIL stall_credit: rom_address=%0d want %0d",
                     rom_address, h_idx + AW'(FD - 1));
          else n_pass++;
          out_ready = 1'b1;
        end
      end else if (rnd) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
      if (!stalled && stall_at >= 0 && pops == stall_at && out_valid) begin
        stalled = 1;
        left = 20;
        out_ready = 1'b0;
        h_idx = out_index;
        h_bit = out_bit;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL extra_result: idx=%0d want none", out_index);
        end else begin
          e = exp_q.pop_front();
          n_chk++;
          if (out_index !== e[AW:1])
            $display("FAIL order: idx=%0d want %0d", out_index, e[AW:1]);
          else n_pass++;
          n_chk++;
          if (out_bit !== e[0])
            $display("FAIL bit idx=%0d: got %b want %b",
                     e[AW:1], out_bit, e[0]);
          else n_pass++;
        end
        pops++;
        last_pop = k;
      end
    end
    n_chk++;
    if (done_at < 0) $display("FAIL frame_timeout: no done, want done");
    else n_pass++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({busy, done, rom_address, out_valid, out_bit, out_index} !== '0)
      $display("FAIL reset_outputs: b=%b d=%b a=%0d v=%b bit=%b i=%0d want 0",
               busy, done, rom_address, out_valid, out_bit, out_index);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_abort();
    int k = 0;
    int pops = 0;
    bit seen = 0;
    @(negedge clk);
    mode = 1'b0;
    start = 1'b1;
    out_ready = 1'b1;
    while (!seen && k < 6000) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      start = 1'b0;
      if (out_valid && out_ready) begin
        n_chk++;
        if (out_index !== AW'(pops))
          $display("FAIL abort_order: idx=%0d want %0d", out_index, pops);
        else n_pass++;
        if (out_index == 5000) seen = 1;
        pops++;
      end
    end
    n_chk++;
    if (!seen) $display("FAIL abort_timeout: index 5000 not seen, want seen");
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({busy, done, rom_address, out_valid, out_bit, out_index} !== '0)
      $display("FAIL abort_reset: b=%b d=%b a=%0d v=%b bit=%b i=%0d want 0",
               busy, done, rom_address, out_valid, out_bit, out_index);
    else n_pass++;
    rst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      n_chk++;
      if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0)
        $display("FAIL abort_quiet: d=%b b=%b v=%b want 0 0 0",
                 done, busy, out_valid);
      else n_pass++;
    end
  endtask

  task automatic test_full_frame();
    int pops, dones, fv, lp, da;
    run_frame(1'b0, -1, 1'b0, 1'b0, pops, dones, fv, lp, da);
    n_chk++;
    if (pops !== N) $display("FAIL full_count: %0d want %0d", pops, N);
    else n_pass++;
    n_chk++;
    if (dones !== 1) $display("FAIL full_done: %0d pulses want 1", dones);
    else n_pass++;
    n_chk++;
    if (fv !== L + 3) $display("FAIL first_valid: edge %0d want %0d", fv, L + 3);
    else n_pass++;
    n_chk++;
    if (lp !== N + L + 2)
      $display("FAIL pass_latency: last pop edge %0d want %0d", lp, N + L + 2);
    else n_pass++;
    n_chk++;
    if (da !== lp + 1) $display("FAIL done_timing: %0d want %0d", da, lp + 1);
    else n_pass++;
  endtask

  task automatic test_stall_boundary();
    int pops, dones, fv, lp, da;
    run_frame(1'b1, 100, 1'b0, 1'b1, pops, dones, fv, lp, da);
    n_chk++;
    if (pops !== N) $display("FAIL stall_count: %0d want %0d", pops, N);
    else n_pass++;
    n_chk++;
    if (dones !== 1) $display("FAIL stall_done: %0d pulses want 1", dones);
    else n_pass++;
    n_chk++;
    if (exp_q.size() !== 0)
      $display("FAIL stall_missing: %0d left want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_random();
    int pops, dones, fv, lp, da;
    run_frame(1'b0, -1, 1'b1, 1'b0, pops, dones, fv, lp, da);
    n_chk++;
    if (pops !== N) $display("FAIL rand_count: %0d want %0d", pops, N);
    else n_pass++;
    n_chk++;
    if (dones !== 1) $display("FAIL rand_done: %0d pulses want 1", dones);
    else n_pass++;
    n_chk++;
    if (da !== lp + 1) $display("FAIL rand_done_timing: %0d want %0d", da, lp + 1);
    else n_pass++;
    out_ready = 1'b1;
  endtask

  task automatic test_single();
    int k = 0;
    int pops = 0;
    int dones = 0;
    int fv = -1;
    int lp = -1;
    int da = -1;
    @(negedge clk);
    start1 = 1'b1;
    while (k < 40 && !(da >= 0 && k >= da + 3)) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      start1 = 1'b0;
      if (out_valid1 && fv < 0) fv = k;
      if (done1 === 1'b1) begin
        dones++;
        if (da < 0) da = k;
      end
      if (out_valid1 && out_ready1) begin
        n_chk++;
        if (out_index1 !== '0 || out_bit1 !== 1'b0)
          $display("FAIL single_result: idx=%0d bit=%b want 0 0",
                   out_index1, out_bit1);
        else n_pass++;
        pops++;
        lp = k;
      end
    end
    n_chk++;
    if (pops !== 1) $display("FAIL single_count: %0d want 1", pops);
    else n_pass++;
    n_chk++;
    if (dones !== 1) $display("FAIL single_done: %0d pulses want 1", dones);
    else n_pass++;
    n_chk++;
    if (fv !== L + 3) $display("FAIL single_latency: %0d want %0d", fv, L + 3);
    else n_pass++;
    n_chk++;
    if (da !== lp + 1) $display("FAIL single_done_timing: %0d want %0d", da, lp + 1);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_abort();
    test_full_frame();
    test_stall_boundary();
    test_random();
    test_single();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
